// File: rtl/loc_pkg.sv
// Shared encodings for the maze-walker location datapath: command ops,
// move directions and the command FSM states.
package loc_pkg;

  typedef enum logic [1:0] {
    OP_MOVE  = 2'b00,
    OP_POP   = 2'b01,
    OP_CLEAR = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  // Bit 0 is the step sign (1 = +1) and the XOR of both bits selects the X axis.
  typedef enum logic [1:0] {
    DIR_YDN = 2'b00,
    DIR_XUP = 2'b01,
    DIR_XDN = 2'b10,
    DIR_YUP = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/loc_stack.sv
// LIFO of packed (x,y) positions with push/pop/clear and occupancy flags.
// Storage is registered; the top entry is read combinationally.
module loc_stack
  import loc_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [DW-1:0]          push_data,
  output logic [DW-1:0]          top_data,
  output logic [$clog2(DEPTH):0] sp,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   sp_q, sp_d;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          wr_en;

  assign wr_idx = sp_q[AW-1:0];
  assign rd_idx = wr_idx - AW'(1);
  assign empty  = (sp_q == '0);
  assign full   = (sp_q == (AW+1)'(DEPTH));
  assign sp     = sp_q;
  assign top_data = mem_q[rd_idx];

  always_comb begin
    sp_d  = sp_q;
    wr_en = 1'b0;
    if (clear) begin
      sp_d = '0;
    end else if (push && !full) begin
      sp_d  = sp_q + (AW+1)'(1);
      wr_en = 1'b1;
    end else if (pop && !empty) begin
      sp_d = sp_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entry contents need no reset; only sp decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/loc_tracker.sv
// Maze-walker location datapath: IDLE/EXEC/RESP command FSM, bounded
// one-step moves and a history stack for backtracking.
module loc_tracker
  import loc_pkg::*;
#(
  parameter int W     = 4,
  parameter int XMAX  = 15,
  parameter int YMAX  = 15,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [1:0]             dir,
  output logic                   resp_valid,
  output logic                   wrong,
  output logic [W-1:0]           x,
  output logic [W-1:0]           y,
  output logic [$clog2(DEPTH):0] sp,
  output logic                   empty,
  output logic                   full
);

  localparam logic [W:0] XLIM = (W+1)'(XMAX);
  localparam logic [W:0] YLIM = (W+1)'(YMAX);

  state_e       state_q, state_d;
  op_e          op_q, op_d;
  logic [1:0]   dir_q, dir_d;
  logic [W-1:0] x_q, x_d, y_q, y_d;
  logic         wrong_q, wrong_d;

  logic         push, pop, clr;
  logic [2*W-1:0] top_data;

  logic         axis_x;
  logic [W:0]   cur, cand, lim;
  logic         move_ok;

  loc_stack #(
    .DW    (2*W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .clear     (clr),
    .push_data ({x_q, y_q}),
    .top_data  (top_data),
    .sp        (sp),
    .empty     (empty),
    .full      (full)
  );

  // Candidate is one bit wider so a step below 0 shows up as a large value
  // and is caught by the same upper-bound compare as a step past MAX.
  always_comb begin
    axis_x  = ^dir_q;
    cur     = axis_x ? {1'b0, x_q} : {1'b0, y_q};
    cand    = dir_q[0] ? cur + (W+1)'(1) : cur - (W+1)'(1);
    lim     = axis_x ? XLIM : YLIM;
    move_ok = (cand <= lim) && !full;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dir_d   = dir_q;
    x_d     = x_q;
    y_d     = y_q;
    wrong_d = wrong_q;
    push    = 1'b0;
    pop     = 1'b0;
    clr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = op_e'(cmd_op);
          dir_d   = dir;
          wrong_d = 1'b0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
        case (op_q)
          OP_MOVE: begin
            if (move_ok) begin
              push = 1'b1;
              if (axis_x) x_d = cand[W-1:0];
              else        y_d = cand[W-1:0];
            end else begin
              wrong_d = 1'b1;
            end
          end
          OP_POP: begin
            if (empty) begin
              wrong_d = 1'b1;
            end else begin
              pop = 1'b1;
              x_d = top_data[2*W-1:W];
              y_d = top_data[W-1:0];
            end
          end
          OP_CLEAR: begin
            clr = 1'b1;
            x_d = '0;
            y_d = '0;
          end
          OP_NOP: begin
          end
        endcase
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      dir_q   <= 2'b00;
      x_q     <= '0;
      y_q     <= '0;
      wrong_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dir_q   <= dir_d;
      x_q     <= x_d;
      y_q     <= y_d;
      wrong_q <= wrong_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign wrong      = wrong_q;
  assign x          = x_q;
  assign y          = y_q;

endmodule
